// File: rtl/rptr_empty.sv
// Read-side pointer and empty/almost-empty/occupancy flags for an async FIFO.
// Optional sticky underflow flag enabled by `define RPTR_UNDERFLOW_DETECT_EN.
module rptr_empty #(
    parameter int ADDRSIZE = 4,
    parameter int AE_LEVEL = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rwptr2,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   rcount,
    output logic                runderflow
);
    localparam int PTRW = ADDRSIZE + 1;

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbnext;
    logic [ADDRSIZE:0] rgnext;
    logic [ADDRSIZE:0] rwbin;
    logic [ADDRSIZE:0] rdiff;

    // A read request while empty is ignored; it never moves the pointer.
    assign rbnext = rbin + PTRW'(rinc & ~rempty);
    assign rgnext = (rbnext >> 1) ^ rbnext;
    assign raddr  = rbin[ADDRSIZE-1:0];

    always_comb begin
        // NOTE: default assignment first so no path leaves rwbin unassigned and infers a latch.
        rwbin = '0;
        rwbin[ADDRSIZE] = rwptr2[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            rwbin[i] = rwbin[i+1] ^ rwptr2[i];
        end
    end

    // Uses the post-read pointer, so the flags never lag the read that drains the FIFO.
    assign rdiff = rwbin - rbnext;

    // NOTE: non-blocking assignments keep all registered state updating together at the edge.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rcount        <= '0;
        end else begin
            rbin          <= rbnext;
            rptr          <= rgnext;
            rempty        <= (rgnext == rwptr2);
            ralmost_empty <= (rdiff <= PTRW'(AE_LEVEL));
            rcount        <= rdiff;
        end
    end

`ifdef RPTR_UNDERFLOW_DETECT_EN
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            runderflow <= 1'b0;
        end else if (rinc && rempty) begin
            runderflow <= 1'b1;
        end
    end
`else
    assign runderflow = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// Directed self-checking bench for rptr_empty at ADDRSIZE=4, AE_LEVEL=2.
module tb_rptr_empty;
    logic       rclk;
    logic       rrst_n;
    logic       rinc;
    logic [4:0] rwptr2;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       ralmost_empty;
    logic [4:0] rcount;
    logic       runderflow;

    int n_checks;
    int n_fail;

`ifdef RPTR_UNDERFLOW_DETECT_EN
    localparam logic UF_EXP = 1'b1;
`else
    localparam logic UF_EXP = 1'b0;
`endif

    rptr_empty #(.ADDRSIZE(4), .AE_LEVEL(2)) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .rinc          (rinc),
        .rwptr2        (rwptr2),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rcount        (rcount),
        .runderflow    (runderflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    logic [4:0] prev_ptr;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rrst_n   = 1'b0;
        rinc     = 1'b0;
        rwptr2   = 5'b00000;
        #12;
        check("rst_rempty", rempty, 1);
        check("rst_ralmost", ralmost_empty, 1);
        check("rst_rptr", rptr, 0);
        check("rst_rcount", rcount, 0);
        check("rst_runderflow", runderflow, 0);
        check("rst_raddr", raddr, 0);
        rrst_n = 1'b1;
        step();

        // Fill with three entries, then drain them.
        rwptr2 = 5'b00010;
        step();
        check("fill_rempty", rempty, 0);
        check("fill_rcount", rcount, 3);
        check("fill_ralmost", ralmost_empty, 0);
        rinc = 1'b1;
        check("rd0_raddr", raddr, 0);
        step();
        check("rd0_rcount", rcount, 2);
        check("rd0_ralmost", ralmost_empty, 1);
        check("rd0_rempty", rempty, 0);
        check("rd1_raddr", raddr, 1);
        step();
        check("rd1_rcount", rcount, 1);
        check("rd1_rempty", rempty, 0);
        check("rd2_raddr", raddr, 2);
        step();
        check("rd2_rcount", rcount, 0);
        check("rd2_rempty", rempty, 1);
        check("rd2_rptr", rptr, 5'b00010);
        check("rd2_raddr_after", raddr, 3);

        // Read while empty: pointer frozen, underflow sticky when enabled.
        step();
        check("uf_raddr", raddr, 3);
        check("uf_rptr", rptr, 5'b00010);
        check("uf_rempty", rempty, 1);
        check("uf_flag", runderflow, UF_EXP);
        rinc = 1'b0;
        step();
        step();
        check("uf_held", runderflow, UF_EXP);
        check("uf_rptr_held", rptr, 5'b00010);

        // Mid-run asynchronous reset while a read is active.
        rwptr2 = gray(5'd5);
        step();
        check("pre_rst_rcount", rcount, 2);
        rinc = 1'b1;
        step();
        check("pre_rst_rcount2", rcount, 1);
        #2;
        rrst_n = 1'b0;
        #1;
        check("async_rempty", rempty, 1);
        check("async_ralmost", ralmost_empty, 1);
        check("async_rptr", rptr, 5'b00000);
        check("async_rcount", rcount, 0);
        check("async_runderflow", runderflow, 0);
        rinc   = 1'b0;
        rwptr2 = 5'b00000;
        step();
        rrst_n = 1'b1;
        step();
        check("post_rst_rempty", rempty, 1);

        // Full occupancy.
        rwptr2 = 5'b11000;
        step();
        check("full_rcount", rcount, 16);
        check("full_rempty", rempty, 0);
        check("full_ralmost", ralmost_empty, 0);
        check("full_runderflow", runderflow, 0);

        // Drain all 16 entries; Gray pointer must change exactly one bit per read.
        rinc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            prev_ptr = rptr;
            step();
            check("drain_gray1", $countones(rptr ^ prev_ptr), 1);
            check("drain_rcount", rcount, 16 - k);
            check("drain_rempty", rempty, (k == 16) ? 1 : 0);
            check("drain_ralmost", ralmost_empty, (16 - k <= 2) ? 1 : 0);
        end
        rinc = 1'b0;

        // Refill to pointer 31 and read up to it.
        rwptr2 = gray(5'd31);
        step();
        check("refill_rcount", rcount, 15);
        rinc = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            prev_ptr = rptr;
            step();
            check("refill_gray1", $countones(rptr ^ prev_ptr), 1);
            check("refill_rcount2", rcount, 15 - k);
        end
        rinc = 1'b0;
        check("at31_rempty", rempty, 1);

        // Wrap from 31 to 0 with data available.
        rwptr2 = gray(5'd1);
        step();
        check("wrap_pre_rptr", rptr, 5'b10000);
        check("wrap_pre_raddr", raddr, 15);
        check("wrap_pre_rcount", rcount, 2);
        rinc = 1'b1;
        prev_ptr = rptr;
        step();
        check("wrap_rptr", rptr, 5'b00000);
        check("wrap_raddr", raddr, 0);
        check("wrap_gray1", $countones(rptr ^ prev_ptr), 1);
        check("wrap_rcount", rcount, 1);
        check("wrap_rempty", rempty, 0);
        step();
        check("wrap_last_rptr", rptr, 5'b00001);
        check("wrap_last_rempty", rempty, 1);
        check("wrap_last_rcount", rcount, 0);
        rinc = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rptr_empty.md
RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4: FIFO depth is 2^ADDRSIZE; pointers are ADDRSIZE+1 bits; legal range 2..12.
REQ-002 SHALL have parameter AE_LEVEL, default 2: almost-empty threshold in entries; legal range 1..2^ADDRSIZE-1.
REQ-003 SHALL have port rclk, input, 1 bit: read clock; the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rrst_n, input, 1 bit: reset; asynchronous assert, active-low.
REQ-005 SHALL have port rinc, input, 1 bit: read request for the current cycle.
REQ-006 SHALL have port rwptr2, input, ADDRSIZE+1 bits: write pointer, Gray code, already synchronized into rclk.
REQ-007 SHALL have port raddr, output, ADDRSIZE bits: memory read address, equal to rbin[ADDRSIZE-1:0].
REQ-008 SHALL have port rptr, output reg, ADDRSIZE+1 bits: read pointer in Gray code, for the write-domain synchronizer.
REQ-009 SHALL have port rempty, output reg, 1 bit: FIFO empty.
REQ-010 SHALL have port ralmost_empty, output reg, 1 bit: occupancy <= AE_LEVEL.
REQ-011 SHALL have port rcount, output reg, ADDRSIZE+1 bits: read-side occupancy, range 0..2^ADDRSIZE.
REQ-012 SHALL have port runderflow, output reg, 1 bit: sticky underflow error.

Function
REQ-013 SHALL hold an internal binary pointer rbin of ADDRSIZE+1 bits; rbnext = rbin + (rinc & !rempty), wrapping modulo 2^(ADDRSIZE+1).
REQ-014 SHALL compute rgnext = (rbnext>>1) ^ rbnext; at each edge rbin <= rbnext and rptr <= rgnext.
REQ-015 SHALL register rempty <= (rgnext == rwptr2), so the read that drains the FIFO raises rempty at that same edge (zero-cycle lag).
REQ-016 SHALL convert rwptr2 to binary rwbin combinationally (rwbin[i] = XOR of rwptr2[ADDRSIZE:i]).
REQ-017 SHALL register rcount <= rwbin - rbnext, taken modulo 2^(ADDRSIZE+1); the value is conservative and never exceeds true occupancy.
REQ-018 SHALL register ralmost_empty <= ((rwbin - rbnext) <= AE_LEVEL); it is high whenever rempty is high.
REQ-019 SHALL NOT advance rbin, rptr or raddr on rinc while rempty=1; the rinc is ignored.
REQ-020 SHALL treat rcount = 2^ADDRSIZE (MSBs of the two Gray pointers differ, second MSBs differ, rest equal) as full-occupancy with rempty=0; the block SHALL NOT flag any error for this case.
REQ-021 SHALL handle the wrap from 2^(ADDRSIZE+1)-1 to 0 seamlessly; the Gray pointer changes exactly one bit per advance.
REQ-022 SHALL evaluate a simultaneous rinc and rwptr2 change using the current-cycle values of both; there are no other priority rules.

Reset
REQ-023 SHALL, while rrst_n=0, asynchronously force rbin=0, rptr=0, rempty=1, ralmost_empty=1, rcount=0 and runderflow=0; raddr is 0 as a consequence.
REQ-024 SHALL release reset synchronously with rclk.
REQ-025 SHALL make any read in flight when reset asserts mid-operation be lost; no state is retained.

Configuration
REQ-026 SHALL be controlled by macro RPTR_UNDERFLOW_DETECT_EN.
- Defined: runderflow is set at the rclk edge where rinc=1 and rempty=1, and is cleared only by reset.
- Undefined: runderflow is constantly 0 with no flop inferred; the port remains present.
- Pointer behaviour per REQ-019 is identical in both cases.

Verification
REQ-027 SHALL cover reset, ADDRSIZE=4, AE_LEVEL=2: assert rrst_n=0 mid-run -> rempty=1, ralmost_empty=1, rptr=5'b00000, rcount=0, runderflow=0 immediately, without waiting for a clock edge.
REQ-028 SHALL cover fill: rwptr2=gray(3)=5'b00010 -> next edge rempty=0, rcount=3, ralmost_empty=0; pulse rinc for 3 cycles -> raddr 0,1,2; rcount 2,1,0; ralmost_empty=1 after the first read; rempty=1 at the third edge.
REQ-029 SHALL cover full: rptr=0 with rwptr2=gray(16)=5'b11000 -> rcount=16, rempty=0, ralmost_empty=0.
REQ-030 SHALL cover wrap: advance rbin from 31 to 0 with data available -> rptr steps 5'b10000 to 5'b00000, raddr 15 to 0, single-bit Gray changes throughout.
REQ-031 SHALL cover underflow: rinc=1 while rempty=1 -> rbin, rptr and raddr unchanged; runderflow=1 with RPTR_UNDERFLOW_DETECT_EN defined and held until reset; runderflow=0 without the macro.
